// File: rtl/slice_adder_arbiter.sv
// Two-requester round-robin front end feeding one 2-bit slice adder.
// Each WIDTH-bit add is performed serially, one 2-bit slice per cycle, LSB first.
//
// state | meaning
// IDLE  | waiting for a request; grant is offered combinationally
// CALC  | one 2-bit slice added per cycle, WIDTH/2 cycles in total
// DONE  | result presented, held until the consumer accepts it
module slice_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id,
    output logic             busy
);

    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry_reg;
    logic             id_reg;
    logic             last_grant;
    logic [IDX_W-1:0] idx;

    logic             grant_id;
    logic             accept;
    logic [1:0]       a_slice;
    logic [1:0]       b_slice;
    logic [2:0]       slice_out;

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    // The only adder in the block: 2 bits plus the carry from the previous slice.
    assign a_slice   = a_reg[{idx, 1'b0} +: 2];
    assign b_slice   = b_reg[{idx, 1'b0} +: 2];
    assign slice_out = {1'b0, a_slice} + {1'b0, b_slice} + {2'b00, carry_reg};

    always_comb begin
        sum_next = sum_reg;
        sum_next[{idx, 1'b0} +: 2] = slice_out[1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_carry  <= 1'b0;
            res_id     <= 1'b0;
            busy       <= 1'b0;
            carry_reg  <= 1'b0;
            idx        <= '0;
            last_grant <= 1'b1;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            id_reg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= grant_id ? req1_a : req0_a;
                        b_reg      <= grant_id ? req1_b : req0_b;
                        id_reg     <= grant_id;
                        last_grant <= grant_id;
                        carry_reg  <= 1'b0;
                        idx        <= '0;
                        sum_reg    <= '0;
                        busy       <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    sum_reg   <= sum_next;
                    carry_reg <= slice_out[2];
                    if (idx == LAST_IDX) begin
                        // Outputs only change here, so they hold between results.
                        res_sum   <= sum_next;
                        res_carry <= slice_out[2];
                        res_id    <= id_reg;
                        res_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slice_adder_arbiter.sv
// Scoreboard bench for slice_adder_arbiter: a cycle-level reference of the
// handshake timing plus plain a+b arithmetic predicts every grant and result.
module tb_slice_adder_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_sum;
    logic         res_carry;
    logic         res_id;
    logic         busy;

    always #5 clk = ~clk;

    slice_adder_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .busy       (busy)
    );

    typedef struct {
        logic         id;
        logic [W:0]   total;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    // Reference model state: what the block should be doing at a high level.
    bit   m_inflight = 0;
    bit   m_done = 0;
    bit   m_last = 1;
    int   m_wait = 0;
    bit   r_seen = 0;

    bit         hold_v = 0;
    logic [W-1:0] h_sum;
    logic       h_carry;
    logic       h_id;

    int   acc_cnt = 0;
    int   acc_id = 0;
    int   hs_cnt = 0;
    int   cyc = 0;
    int   last_hs_cyc = -100;
    bit   gap_chk = 0;

    logic exp_r0, exp_r1, g;
    exp_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("ready_in_reset", {30'd0, req1_ready, req0_ready}, 32'd0);
            if (r_seen) begin
                chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_res_sum", {24'd0, res_sum}, 32'd0);
                chk("rst_res_carry", {31'd0, res_carry}, 32'd0);
                chk("rst_res_id", {31'd0, res_id}, 32'd0);
            end
            m_inflight = 0;
            m_done = 0;
            m_last = 1;
            m_wait = 0;
            hold_v = 0;
            sb.delete();
            r_seen = 1;
        end else begin
            if (r_seen) begin
                chk("post_rst_sum", {24'd0, res_sum}, 32'd0);
                chk("post_rst_carry", {31'd0, res_carry}, 32'd0);
                chk("post_rst_id", {31'd0, res_id}, 32'd0);
            end
            r_seen = 0;
            chk("busy", {31'd0, busy}, {31'd0, (m_inflight || m_done)});
            chk("res_valid", {31'd0, res_valid}, {31'd0, m_done});

            exp_r0 = 0;
            exp_r1 = 0;
            g = (req0_valid && req1_valid) ? !m_last : req1_valid;
            if (!m_inflight && !m_done && (req0_valid || req1_valid)) begin
                if (g) exp_r1 = 1;
                else exp_r0 = 1;
            end
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, exp_r0});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, exp_r1});

            if (hold_v) begin
                chk("hold_sum", {24'd0, res_sum}, {24'd0, h_sum});
                chk("hold_carry", {31'd0, res_carry}, {31'd0, h_carry});
                chk("hold_id", {31'd0, res_id}, {31'd0, h_id});
            end
            hold_v = res_valid && !res_ready;
            h_sum = res_sum;
            h_carry = res_carry;
            h_id = res_id;

            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("res_sum", {24'd0, res_sum}, {24'd0, e.total[W-1:0]});
                    chk("res_carry", {31'd0, res_carry}, {31'd0, e.total[W]});
                    chk("res_id", {31'd0, res_id}, {31'd0, e.id});
                end
                hs_cnt++;
                last_hs_cyc = cyc;
            end

            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                if (gap_chk) chk("accept_gap", cyc - last_hs_cyc, 32'd1);
                acc_id = (req1_valid && req1_ready) ? 1 : 0;
                acc_cnt++;
            end

            if (exp_r0 || exp_r1) begin
                e.id = g;
                e.total = g ? ({1'b0, req1_a} + {1'b0, req1_b})
                            : ({1'b0, req0_a} + {1'b0, req0_b});
                sb.push_back(e);
                m_inflight = 1;
                m_wait = W / 2;
                m_last = g;
            end else if (m_inflight) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_inflight = 0;
                    m_done = 1;
                end
            end else if (m_done && res_ready) begin
                m_done = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc();
        int start = acc_cnt;
        int n = 0;
        while (acc_cnt == start && n < 60) begin
            step();
            n++;
        end
        if (acc_cnt == start) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_hs();
        int start = hs_cnt;
        int n = 0;
        while (hs_cnt == start && n < 60) begin
            step();
            n++;
        end
        if (hs_cnt == start) chk("handshake_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_inflight || m_done || sb.size() != 0) && n < 100) begin
            step();
            n++;
        end
        if (m_inflight || m_done || sb.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        wait_acc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        int start;
        int n;
        repeat (3) step();
        rst_n = 1'b1;
        res_ready = 1'b1;

        // Single requester, carry out of the top bit.
        issue(0, 8'hFF, 8'h01);
        wait_idle();

        // Contention right after reset: requester 0 first, then requester 1.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
        req1_a = 8'h35; req1_b = 8'h4A; req1_valid = 1'b1;
        wait_acc();
        req0_valid = 1'b0;
        chk("first_grant", acc_id, 32'd0);
        wait_acc();
        req1_valid = 1'b0;
        chk("second_grant", acc_id, 32'd1);
        wait_idle();

        // Both held valid: strict alternation with a one-cycle bubble.
        req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
        req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_acc();
            gap_chk = 1;
            chk("rr_order", acc_id, i % 2);
            if (acc_id == 0) begin req0_a = W'($urandom); req0_b = W'($urandom); end
            else begin req1_a = W'($urandom); req1_b = W'($urandom); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        gap_chk = 0;
        wait_idle();

        // Consumer stalls in DONE while another request waits.
        res_ready = 1'b0;
        issue(0, 8'hA5, 8'h5A);
        req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
        n = 0;
        while (!res_valid && n < 20) begin step(); n++; end
        chk("stall_valid_seen", {31'd0, res_valid}, 32'd1);
        repeat (3) step();
        chk("stall_sum", {24'd0, res_sum}, 32'hFF);
        chk("stall_carry", {31'd0, res_carry}, 32'd0);
        res_ready = 1'b1;
        wait_hs();
        req1_valid = 1'b0;
        wait_idle();

        // Reset during the second CALC cycle abandons the operation.
        issue(0, W'($urandom), W'($urandom));
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        start = hs_cnt;
        repeat (8) step();
        chk("no_result_after_abort", hs_cnt, start);
        issue(1, W'($urandom), W'($urandom));
        wait_idle();

        // Operand change right after acceptance must not disturb the result.
        issue(0, 8'h80, 8'h80);
        req0_a = 8'h00;
        req0_b = 8'h00;
        wait_idle();

        // Random traffic with random consumer back-pressure.
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = W'($urandom); req0_b = W'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        step();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
